fpa_result_collector: RTL and testbench
=======================================

Name: fpa_result_collector

Overview:
- Downstream stage of fpa_adder. Tracks operations issued to the adder and captures `out` when each one completes.
- Classifies each captured IEEE-754 single-precision result and buffers it in a small FIFO with a valid/ready output handshake.
- Because fpa_adder cannot stall, the block gives issue credit upstream so that no result is ever dropped.

Parameters:
- ADDER_LAT, 1: clock cycles from an issue handshake until the matching result is stable on `adder_out`. Legal range 1..8.
- DEPTH, 4: number of result FIFO entries. Power of two, 2..16.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- issue_valid, input, 1: upstream presents a, b and inp_op to fpa_adder this cycle.
- issue_ready, output, 1: collector can accept one more issued operation.
- adder_out, input, 32: fpa_adder `out` bus.
- res_valid, output, 1: res_data and res_flags hold the FIFO head.
- res_ready, input, 1: consumer accepts the head.
- res_data, output, 32: buffered result word.
- res_flags, output, 5: {sign, nan, inf, zero, denorm} of res_data.
- sticky_exc, output, 3: sticky {nan, inf, denorm} seen since the last clear.
- sticky_clr, input, 1: clear sticky_exc.
- occupancy, output, clog2(DEPTH)+1: current number of FIFO entries.

Behaviour:
- Reset (async, rst=1):
  - Valid pipeline and FIFO are emptied; pointers go to 0.
  - issue_ready=1, res_valid=0, res_data=0, res_flags=0, sticky_exc=0, occupancy=0.
  - Any in-flight operations are discarded.
  - Reset deasserting mid-stream needs no special recovery.
- Issue: a handshake occurs when issue_valid & issue_ready at a rising edge.
  - The handshake shifts a 1 into the valid pipeline vp[ADDER_LAT-1:0]. Otherwise a 0 is shifted in.
- Capture:
  - When the tap vp[ADDER_LAT-1] is 1, adder_out is sampled on that edge and pushed into the FIFO.
  - Result latency is ADDER_LAT cycles from issue to push. res_valid rises on the following cycle.
- Credit: issue_ready = (occupancy + popcount(vp)) < DEPTH, where popcount counts the 1s in vp.
  - Computed combinationally from registered state only.
  - A same-cycle pop does not free credit until the next cycle.
  - The FIFO therefore never overflows. Overflow is unreachable by construction; the verifier asserts this.
- Output:
  - A pop occurs when res_valid & res_ready.
  - res_valid = (occupancy != 0).
  - res_data and res_flags come from the head entry and are stable while res_valid=1 and res_ready=0.
- Simultaneous push and pop: both happen, occupancy is unchanged, and pointers wrap modulo DEPTH.
- Empty FIFO with a push: the entry appears on the next cycle. There is no combinational bypass.
- Classification, with e = bits[30:23] and m = bits[22:0]:
  - nan = (e==8'hFF) & (m!=0)
  - inf = (e==8'hFF) & (m==0)
  - zero = (e==0) & (m==0)
  - denorm = (e==0) & (m!=0)
  - sign = bit31
  - Flags are computed at push time and stored with the entry.
- Sticky register:
  - On each push, sticky_exc |= {nan, inf, denorm}.
  - When sticky_clr is high, sticky_exc clears, except that set bits from a push in the same cycle win.
- Out-of-order: results are never reordered. FIFO order equals issue order.

Test Plan:
- Reset, then with ADDER_LAT=1 issue one op while the bench drives adder_out=32'h447878F6 one cycle later → res_valid=1 two cycles after issue, res_data=32'h447878F6, res_flags=5'b00000.
- Push 32'h7FC00000, 32'hFF800000, 32'h00000000 and 32'h80000001 with res_ready=1 → res_flags = 01000, 10100, 00010, 10001 respectively, and sticky_exc=3'b111 (nan, inf and denorm all seen).
- Hold res_ready=0 and issue continuously (DEPTH=4) → issue_ready drops after 4 issues, occupancy saturates at 4, and no data is lost. Then drain with res_ready=1 → all 4 entries come out in order and issue_ready returns to 1.
- Push and pop in the same cycle for 20 cycles with distinct values → occupancy stays constant, pointers wrap, and the output sequence equals the input sequence.
- Assert rst asynchronously with 2 entries buffered and 1 in flight → outputs reach their reset values immediately (before the next edge), and the in-flight result is not pushed.
- Assert sticky_clr in the same cycle as a NaN push → sticky_exc=3'b100. Then sticky_clr alone → sticky_exc=3'b000.

Source files
------------

// File: rtl/fpa_result_collector.sv
// ---------------------------------------------------------------------------
// fpa_result_collector
//
// Purpose:
//   Downstream stage of fpa_adder.
//   - Tracks operations issued to the adder with a valid pipeline whose
//     length matches the adder latency.
//   - Captures adder_out when each operation completes.
//   - Classifies each result as an IEEE-754 single-precision value.
//   - Buffers results in order in a small FIFO with a valid/ready output.
//   The adder cannot stall, so upstream only gets issue credit while every
//   in-flight result is guaranteed a free FIFO slot.
//
// Parameters:
//   ADDER_LAT : cycles from issue handshake to stable adder_out (1..8)
//   DEPTH     : FIFO entries (power of two, 2..16)
//
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   issue_valid : upstream presents an operation to the adder this cycle
//   issue_ready : collector has credit for one more operation
//   adder_out   : adder result bus
//   res_valid   : res_data/res_flags hold the FIFO head
//   res_ready   : consumer accepts the head
//   res_data    : buffered result word
//   res_flags   : {sign, nan, inf, zero, denorm} of res_data
//   sticky_exc  : sticky {nan, inf, denorm} seen since the last clear
//   sticky_clr  : clear sticky_exc (a same-cycle push still sets its bits)
//   occupancy   : current number of FIFO entries
// ---------------------------------------------------------------------------
module fpa_result_collector #(
    parameter int ADDER_LAT = 1,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [31:0]                adder_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [31:0]                res_data,
    output logic [4:0]                 res_flags,
    output logic [2:0]                 sticky_exc,
    input  logic                       sticky_clr,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Registered state
    logic [ADDER_LAT-1:0] r_vp;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic [2:0]           r_sticky;
    logic [31:0]          r_mem_data  [DEPTH];
    logic [4:0]           r_mem_flags [DEPTH];

    // Combinational signals
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic [ADDER_LAT-1:0] w_vp_next;
    logic [4:0]           w_inflight;
    logic [5:0]           w_used;
    logic [4:0]           w_flags_in;
    logic [2:0]           w_exc_in;

    // Classify a single-precision word into {sign, nan, inf, zero, denorm}
    function automatic logic [4:0] classify(input logic [31:0] bits);
        logic [7:0]  e;
        logic [22:0] m;
        logic        e_max;
        logic        e_min;
        logic        m_nz;
        e     = bits[30:23];
        m     = bits[22:0];
        e_max = (e == 8'hFF);
        e_min = (e == 8'h00);
        m_nz  = (m != 23'd0);
        return {bits[31], e_max & m_nz, e_max & ~m_nz, e_min & ~m_nz, e_min & m_nz};
    endfunction

    // Credit: FIFO entries plus results still travelling through the adder.
    // Uses registered state only, so a pop frees credit one cycle later.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ADDER_LAT; i++) begin
            w_inflight = w_inflight + 5'(r_vp[i]);
        end
    end

    assign w_used      = 6'(r_count) + 6'(w_inflight);
    assign issue_ready = (w_used < 6'(DEPTH));
    assign w_issue     = issue_valid & issue_ready;

    // Valid pipeline: the handshake enters at bit 0, the tap is the MSB
    generate
        if (ADDER_LAT == 1) begin : g_vp_one
            assign w_vp_next = w_issue;
        end else begin : g_vp_many
            assign w_vp_next = {r_vp[ADDER_LAT-2:0], w_issue};
        end
    endgenerate

    assign w_push     = r_vp[ADDER_LAT-1];
    assign res_valid  = (r_count != '0);
    assign w_pop      = res_valid & res_ready;
    assign w_flags_in = classify(adder_out);
    assign w_exc_in   = {w_flags_in[3], w_flags_in[2], w_flags_in[0]};

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vp     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sticky <= '0;
        end else begin
            r_vp <= w_vp_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Clear first, then OR in a same-cycle push so its bits survive
            r_sticky <= (sticky_clr ? 3'b000 : r_sticky) | (w_push ? w_exc_in : 3'b000);
        end
    end

    // Storage array, no reset: contents are only visible while occupied
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr]  <= adder_out;
            r_mem_flags[r_wr_ptr] <= w_flags_in;
        end
    end

    // Head is gated by occupancy so the outputs read zero whenever empty,
    // including immediately after reset.
    assign res_data   = res_valid ? r_mem_data[r_rd_ptr]  : 32'd0;
    assign res_flags  = res_valid ? r_mem_flags[r_rd_ptr] : 5'd0;
    assign sticky_exc = r_sticky;
    assign occupancy  = r_count;

endmodule

// File: tb/tb_fpa_result_collector.sv
// ---------------------------------------------------------------------------
// tb_fpa_result_collector
//
// Directed bench for fpa_result_collector with ADDER_LAT=1 and DEPTH=4.
// The bench plays the adder role by driving adder_out one cycle after each
// accepted issue. Inputs are driven and outputs sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_fpa_result_collector;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] adder_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_flags;
    logic [2:0]  sticky_exc;
    logic        sticky_clr;
    logic [2:0]  occupancy;

    int n_pass  = 0;
    int n_total = 0;

    fpa_result_collector #(
        .ADDER_LAT (1),
        .DEPTH     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .adder_out   (adder_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_flags   (res_flags),
        .sticky_exc  (sticky_exc),
        .sticky_clr  (sticky_clr),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-14s obs=%08h exp=%08h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One issue, then present the result on adder_out during the next cycle
    task automatic push_val(input logic [31:0] v);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        adder_out   = v;
        step();
    endtask

    logic [31:0] vals   [4];
    logic [4:0]  flags  [4];
    logic        exp_rdy[6];
    logic        hs;
    int          issued;

    initial begin
        vals    = '{32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h80000001};
        flags   = '{5'b01000, 5'b10100, 5'b00010, 5'b10001};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst         = 1'b1;
        issue_valid = 1'b0;
        adder_out   = 32'd0;
        res_ready   = 1'b0;
        sticky_clr  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_ready", 32'(issue_ready), 32'd1);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_flags", 32'(res_flags), 32'd0);
        check("rst_sticky", 32'(sticky_exc), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);

        // Single issue, latency check
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        adder_out   = 32'h447878F6;
        check("lat_valid_early", 32'(res_valid), 32'd0);
        step();
        check("lat_valid", 32'(res_valid), 32'd1);
        check("lat_data", res_data, 32'h447878F6);
        check("lat_flags", 32'(res_flags), 32'd0);
        check("lat_occ", 32'(occupancy), 32'd1);
        res_ready = 1'b1;
        step();
        check("lat_drained", 32'(occupancy), 32'd0);

        // Classification and sticky accumulation
        for (int i = 0; i < 4; i++) begin
            push_val(vals[i]);
            check("cls_data", res_data, vals[i]);
            check("cls_flags", 32'(res_flags), 32'(flags[i]));
        end
        check("cls_sticky", 32'(sticky_exc), 32'b111);
        step();
        check("cls_drained", 32'(occupancy), 32'd0);

        // Clear racing a NaN push: the push's bit survives
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        adder_out   = 32'h7FC00000;
        sticky_clr  = 1'b1;
        step();
        sticky_clr  = 1'b0;
        check("clr_with_nan", 32'(sticky_exc), 32'b100);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("clr_alone", 32'(sticky_exc), 32'b000);
        step();
        check("clr_drained", 32'(occupancy), 32'd0);

        // Back-pressure: credit stops at DEPTH, then drain in order
        res_ready   = 1'b0;
        issued      = 0;
        issue_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            hs = issue_ready;
            step();
            if (hs) begin
                adder_out = 32'h3F800010 + 32'(issued);
                issued++;
            end
            check("bp_ready", 32'(issue_ready), 32'(exp_rdy[k]));
        end
        issue_valid = 1'b0;
        check("bp_issued", 32'(issued), 32'd4);
        check("bp_occ", 32'(occupancy), 32'd4);
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_order", res_data, 32'h3F800010 + 32'(k));
            step();
        end
        check("bp_empty", 32'(occupancy), 32'd0);
        check("bp_credit", 32'(issue_ready), 32'd1);

        // Simultaneous push and pop with pointer wrap
        issue_valid = 1'b1;
        res_ready   = 1'b1;
        step();
        adder_out = 32'h40000000;
        for (int i = 1; i <= 21; i++) begin
            step();
            adder_out = 32'h40000000 + 32'(i);
            check("pp_occ", 32'(occupancy), 32'd1);
            check("pp_data", res_data, 32'h40000000 + 32'(i - 1));
        end
        issue_valid = 1'b0;
        step();
        step();
        check("pp_drained", 32'(occupancy), 32'd0);

        // Asynchronous reset with 2 buffered and 1 in flight
        res_ready = 1'b0;
        push_val(32'h7FC00001);
        push_val(32'h3F800000);
        check("ar_occ_pre", 32'(occupancy), 32'd2);
        check("ar_sticky_pre", 32'(sticky_exc), 32'b100);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        adder_out   = 32'h12345678;
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(res_valid), 32'd0);
        check("ar_occ", 32'(occupancy), 32'd0);
        check("ar_data", res_data, 32'd0);
        check("ar_flags", 32'(res_flags), 32'd0);
        check("ar_sticky", 32'(sticky_exc), 32'd0);
        check("ar_ready", 32'(issue_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        check("ar_no_push", 32'(occupancy), 32'd0);
        check("ar_no_valid", 32'(res_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
